sha256_msg_padder: RTL and testbench

Streaming SHA-256 message padder that sits directly upstream of the SHA-256 core. It accepts a message one byte per cycle over a valid/ready handshake. It emits big-endian 32-bit schedule words, 16 per 512-bit block, with FIPS 180-4 padding already applied: a 0x80 byte, zero fill, and the 64-bit big-endian bit length. Block and message boundaries are flagged so the core can start compression on each block and finish on the last one.

---
 rtl/sha256_msg_padder.sv | 178 +++++++++++++++++
 tb/tb_sha256_msg_padder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_padder.sv
// ---------------------------------------------------------------------------
// sha256_msg_padder
//
// Streaming SHA-256 message padder. Accepts the message one byte per cycle
// and emits big-endian 32-bit schedule words, 16 per 512-bit block, with the
// 0x80 marker, zero fill and 64-bit big-endian bit length already appended.
//
// Ports
//   clk, rst_n      : clock (rising edge), asynchronous active-low reset
//   in_data/valid   : message byte and its valid strobe
//   in_last         : qualifies the final message byte (with in_valid)
//   in_empty        : one-cycle request to hash a zero-length message (IDLE)
//   in_ready        : byte is accepted this cycle
//   out_word/valid  : schedule word (first byte in [31:24]) and valid
//   out_ready       : consumer accepts the word
//   out_blk_last    : word 15 of a block
//   out_msg_last    : word 15 of the final block
//   busy            : a message is in progress
// ---------------------------------------------------------------------------
module sha256_msg_padder #(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  input  logic        in_empty,
  output logic        in_ready,
  output logic [31:0] out_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_blk_last,
  output logic        out_msg_last,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_PAD80,
    S_ZERO,
    S_LEN
  } state_t;

  state_t             state_q, state_d;
  logic [5:0]         pos_q, pos_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         len_idx_q, len_idx_d;
  logic [23:0]        asm_q, asm_d;
  logic [31:0]        out_word_q, out_word_d;
  logic               out_valid_q, out_valid_d;
  logic               out_blk_last_q, out_blk_last_d;
  logic               out_msg_last_q, out_msg_last_d;
  logic               run_q, run_d;

  logic               stall;
  logic               accepting;
  logic               take;
  logic               step;
  logic [7:0]         byte_v;

  // Length byte idx (0 = most significant) of the 64-bit field {0, cnt, 3'b0}.
  function automatic logic [7:0] len_byte(input logic [CNT_W-1:0] cnt,
                                          input logic [2:0]       idx);
    logic [63:0] bits;
    bits = 64'({cnt, 3'b000});
    bits = bits << (8 * idx);
    return bits[63:56];
  endfunction

  always_comb begin
    stall     = out_valid_q && !out_ready;
    accepting = (state_q == S_IDLE || state_q == S_DATA) && run_q && !stall;
    take      = in_valid && accepting;

    state_d        = state_q;
    pos_d          = pos_q;
    cnt_d          = cnt_q;
    len_idx_d      = len_idx_q;
    asm_d          = asm_q;
    out_word_d     = out_word_q;
    out_valid_d    = out_valid_q;
    out_blk_last_d = out_blk_last_q;
    out_msg_last_d = out_msg_last_q;
    run_d          = 1'b1;
    step           = 1'b0;
    byte_v         = 8'h00;

    // A pending unaccepted word freezes the whole engine.
    if (!stall) begin
      case (state_q)
        S_IDLE, S_DATA: begin
          if (take) begin
            step    = 1'b1;
            byte_v  = in_data;
            cnt_d   = cnt_q + 1'b1;
            state_d = in_last ? S_PAD80 : S_DATA;
          end else if (state_q == S_IDLE && in_empty && run_q) begin
            state_d = S_PAD80;
            cnt_d   = '0;
          end
        end
        S_PAD80: begin
          step    = 1'b1;
          byte_v  = 8'h80;
          // Landing on position 56 means the length fits right away.
          state_d = (pos_q == 6'd55) ? S_LEN : S_ZERO;
        end
        S_ZERO: begin
          step   = 1'b1;
          byte_v = 8'h00;
          if (pos_q == 6'd55) state_d = S_LEN;
        end
        S_LEN: begin
          step      = 1'b1;
          byte_v    = len_byte(cnt_q, len_idx_q);
          len_idx_d = len_idx_q + 3'd1;
          if (len_idx_q == 3'd7) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase

      // Not stalled: any previous word has been consumed (or none was held).
      out_valid_d    = 1'b0;
      out_blk_last_d = 1'b0;
      out_msg_last_d = 1'b0;

      if (step) begin
        pos_d = pos_q + 6'd1;
        asm_d = {asm_q[15:0], byte_v};
        if (pos_q[1:0] == 2'd3) begin
          out_word_d     = {asm_q, byte_v};
          out_valid_d    = 1'b1;
          out_blk_last_d = (pos_q == 6'd63);
          out_msg_last_d = (pos_q == 6'd63) && (state_q == S_LEN);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      pos_q          <= '0;
      cnt_q          <= '0;
      len_idx_q      <= '0;
      asm_q          <= '0;
      out_word_q     <= '0;
      out_valid_q    <= 1'b0;
      out_blk_last_q <= 1'b0;
      out_msg_last_q <= 1'b0;
      run_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      pos_q          <= pos_d;
      cnt_q          <= cnt_d;
      len_idx_q      <= len_idx_d;
      asm_q          <= asm_d;
      out_word_q     <= out_word_d;
      out_valid_q    <= out_valid_d;
      out_blk_last_q <= out_blk_last_d;
      out_msg_last_q <= out_msg_last_d;
      run_q          <= run_d;
    end
  end

  assign in_ready     = accepting;
  assign out_word     = out_word_q;
  assign out_valid    = out_valid_q;
  assign out_blk_last = out_blk_last_q;
  assign out_msg_last = out_msg_last_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_sha256_msg_padder.sv
// ---------------------------------------------------------------------------
// tb_sha256_msg_padder
//
// Directed and randomized bench for sha256_msg_padder. Expected word streams
// come from a byte-level padding model (message, 0x80, zeros to 56 mod 64,
// 64-bit length) split into 32-bit words.
// ---------------------------------------------------------------------------
module tb_sha256_msg_padder;

  typedef logic [7:0]  byte_q_t[$];
  typedef logic [33:0] ent_t;        // {word, blk_last, msg_last}
  typedef ent_t        ent_q_t[$];

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_empty;
  logic        in_ready;
  logic [31:0] out_word;
  logic        out_valid;
  logic        out_ready;
  logic        out_blk_last;
  logic        out_msg_last;
  logic        busy;

  int          n_pass  = 0;
  int          n_total = 0;
  int          n_fail  = 0;
  bit          rdy_rand = 1'b0;
  ent_q_t      rx;
  bit          stall_prev = 1'b0;
  logic [31:0] prev_word = '0;

  sha256_msg_padder #(.CNT_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_last      (in_last),
    .in_empty     (in_empty),
    .in_ready     (in_ready),
    .out_word     (out_word),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_blk_last (out_blk_last),
    .out_msg_last (out_msg_last),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Consumer: ready is either held high or toggled randomly.
  always @(posedge clk) begin
    #1;
    out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: record accepted words, check stability/in_ready while stalled.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready)
      rx.push_back({out_word, out_blk_last, out_msg_last});
    if (rst_n && out_valid && !out_ready) begin
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      if (stall_prev) chk("stall_word_stable", 64'(out_word), 64'(prev_word));
    end
    stall_prev = rst_n && out_valid && !out_ready;
    prev_word  = out_word;
  end

  // Reference model: pad at byte level, then group into words.
  function automatic ent_q_t build_exp(input byte_q_t m);
    byte_q_t     p;
    ent_q_t      e;
    logic [63:0] bl;
    int          nw;
    p  = m;
    bl = 64'(m.size()) * 64'd8;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int k = 7; k >= 0; k--) p.push_back(bl[8*k +: 8]);
    nw = p.size() / 4;
    for (int w = 0; w < nw; w++)
      e.push_back({p[4*w], p[4*w+1], p[4*w+2], p[4*w+3],
                   1'(w % 16 == 15), 1'(w == nw - 1)});
    return e;
  endfunction

  // Drive the first n bytes of m (in_last on the true final byte),
  // inserting random idle cycles when gaps is set.
  task automatic send_msg(input byte_q_t m, input int n, input bit gaps);
    int i = 0;
    int guard = 0;
    bit acc;
    while (i < n && guard < 5000) begin
      in_valid = !(gaps && ($urandom_range(0, 3) == 0));
      in_data  = m[i];
      in_last  = (i == m.size() - 1);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) i++;
      guard++;
    end
    chk("send_within_budget", 64'(i), 64'(n));
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic wait_done(input int n);
    int g = 0;
    while ((rx.size() < n || busy || out_valid) && g < 3000) begin
      @(posedge clk);
      #1;
      g++;
    end
  endtask

  task automatic compare(input string tag, input ent_q_t e);
    chk({tag, "_count"}, 64'(rx.size()), 64'(e.size()));
    for (int k = 0; k < e.size() && k < rx.size(); k++)
      chk($sformatf("%s_w%0d", tag, k), 64'(rx[k]), 64'(e[k]));
  endtask

  task automatic run_msg(input string tag, input byte_q_t m, input bit gaps);
    ent_q_t e;
    rx.delete();
    e = build_exp(m);
    send_msg(m, m.size(), gaps);
    wait_done(e.size());
    compare(tag, e);
  endtask

  initial begin
    byte_q_t m, m2, abc;
    ent_q_t  e;
    rst_n     = 1'b0;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_empty  = 1'b0;
    out_ready = 1'b1;
    abc = '{8'h61, 8'h62, 8'h63};

    // Reset state
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_word", 64'(out_word), 64'd0);
    chk("rst_blk_last", 64'(out_blk_last), 64'd0);
    chk("rst_msg_last", 64'(out_msg_last), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready_before_edge", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    chk("rel_in_ready_after_edge", 64'(in_ready), 64'd1);

    // "abc"
    run_msg("abc", abc, 1'b0);
    if (rx.size() == 16) begin
      chk("abc_word0_lit", 64'(rx[0]), 64'({32'h61626380, 2'b00}));
      chk("abc_word15_lit", 64'(rx[15]), 64'({32'h00000018, 2'b11}));
    end

    // Empty message
    rx.delete();
    in_empty = 1'b1;
    @(posedge clk);
    #1;
    in_empty = 1'b0;
    chk("empty_busy", 64'(busy), 64'd1);
    wait_done(16);
    m.delete();
    compare("empty", build_exp(m));
    if (rx.size() == 16) begin
      chk("empty_word0_lit", 64'(rx[0]), 64'({32'h80000000, 2'b00}));
      chk("empty_word15_lit", 64'(rx[15]), 64'({32'h00000000, 2'b11}));
    end

    // 55 and 56 bytes of 0x41
    m.delete();
    for (int k = 0; k < 55; k++) m.push_back(8'h41);
    run_msg("len55", m, 1'b0);
    if (rx.size() == 16) begin
      chk("len55_word13_lit", 64'(rx[13]), 64'({32'h41414180, 2'b00}));
      chk("len55_word15_lit", 64'(rx[15]), 64'({32'h000001B8, 2'b11}));
    end
    m.push_back(8'h41);
    run_msg("len56", m, 1'b0);
    if (rx.size() == 32) begin
      chk("len56_word14_lit", 64'(rx[14]), 64'({32'h80000000, 2'b00}));
      chk("len56_word15_lit", 64'(rx[15]), 64'({32'h00000000, 2'b10}));
      chk("len56_word31_lit", 64'(rx[31]), 64'({32'h000001C0, 2'b11}));
    end

    // Backpressure on "abc"
    rdy_rand = 1'b1;
    run_msg("abc_bp", abc, 1'b1);

    // Random messages under random backpressure
    for (int r = 0; r < 4; r++) begin
      m.delete();
      for (int k = 0; k < int'($urandom_range(1, 130)); k++) m.push_back(8'($urandom));
      run_msg($sformatf("rnd%0d", r), m, 1'b1);
    end

    // Back-to-back messages
    m.delete();
    m2.delete();
    for (int k = 0; k < 61; k++) m.push_back(8'($urandom));
    for (int k = 0; k < 7; k++) m2.push_back(8'($urandom));
    rx.delete();
    e = build_exp(m);
    e = {e, build_exp(m2)};
    send_msg(m, m.size(), 1'b0);
    send_msg(m2, m2.size(), 1'b0);
    wait_done(e.size());
    compare("b2b", e);
    rdy_rand = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset mid-message
    m.delete();
    for (int k = 0; k < 20; k++) m.push_back(8'($urandom));
    send_msg(m, 5, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_rel_in_ready_before_edge", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    chk("mid_rel_in_ready_after_edge", 64'(in_ready), 64'd1);
    rx.delete();
    repeat (10) @(posedge clk);
    #1;
    chk("mid_rst_no_words", 64'(rx.size()), 64'd0);
    chk("mid_rst_idle", 64'(busy), 64'd0);
    run_msg("abc_after_rst", abc, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
